// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared constants and W-stage payload layout for the MEM->WB pipeline register.
// The payload is packed MSB-first as {valid, rfwe, mtorfsel, aluout, dmrd, rtd}.
package mem_wb_pipe_reg_pkg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic          rfwe;
    logic          mtorfsel;
    logic [DW-1:0] aluout;
    logic [DW-1:0] dmrd;
    logic [AW-1:0] rtd;
  } wb_payload_t;

  // Payload width for arbitrary datapath/address widths, in the layout above.
  function automatic int payload_w(input int dw, input int aw);
    return 3 + 2 * dw + aw;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// M-stage inputs, EX-stage forward-compare addresses and W-stage outputs of the MEM->WB register.
// slave is the register's view; master is the driving pipeline's view.
interface mem_wb_pipe_reg_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) ();

  logic             stall;
  logic             flush;
  logic             validM;
  logic             rfweM;
  logic             mtorfselM;
  logic [DW-1:0]    aluoutM;
  logic [DW-1:0]    dmrdM;
  logic [AW-1:0]    rtdM;
  logic [AW-1:0]    srcA_E;
  logic [AW-1:0]    srcB_E;

  logic             validW;
  logic             rfweW;
  logic             mtorfselW;
  logic [DW-1:0]    aluoutW;
  logic [DW-1:0]    dmrdW;
  logic [AW-1:0]    rtdW;
  logic [DW-1:0]    wbdataW;
  logic             fwdA_W;
  logic             fwdB_W;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  stall, flush, validM, rfweM, mtorfselM, aluoutM, dmrdM, rtdM, srcA_E, srcB_E,
    output validW, rfweW, mtorfselW, aluoutW, dmrdW, rtdW, wbdataW, fwdA_W, fwdB_W, retired
  );

  modport master (
    output stall, flush, validM, rfweM, mtorfselM, aluoutM, dmrdM, rtdM, srcA_E, srcB_E,
    input  validW, rfweW, mtorfselW, aluoutW, dmrdW, rtdW, wbdataW, fwdA_W, fwdB_W, retired
  );

endinterface

// File: rtl/mem_wb_pipe_reg_pipe_reg.sv
// Generic pipeline stage register with reset > flush > stall > load priority.
// On flush, bits set in CLR_MASK are cleared and all other bits hold.
module mem_wb_pipe_reg_pipe_reg #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next-state selection: bubble, hold or load.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = q_q & ~CLR_MASK;
    end else if (stall_i) begin
      q_d = q_q;
    end else begin
      q_d = d_i;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/stall/flush, zero-register write suppression,
// write-back data mux, W-stage forwarding match flags and a retired-instruction counter.
module mem_wb_pipe_reg #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int CNT_W     = 32,
  parameter int ZERO_SUPP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_wb_pipe_reg_if.slave      bus
);

  import mem_wb_pipe_reg_pkg::*;

  localparam int            PW       = payload_w(DW, AW);
  localparam logic [PW-1:0] CLR_MASK = {2'b11, {(PW - 2){1'b0}}};

  logic             zero_dst_s;
  logic             rfwe_m_s;
  logic [PW-1:0]    payload_d;
  logic [PW-1:0]    payload_q;
  logic [CNT_W-1:0] retired_d;
  logic [CNT_W-1:0] retired_q;
  logic             load_s;

  // Write-enable qualification: bubbles never write, r0 writes optionally dropped.
  always_comb begin
    zero_dst_s = (ZERO_SUPP != 0) && (bus.rtdM == {AW{1'b0}});
    rfwe_m_s   = bus.rfweM & bus.validM & ~zero_dst_s;
  end

  assign payload_d = {bus.validM, rfwe_m_s, bus.mtorfselM, bus.aluoutM, bus.dmrdM, bus.rtdM};

  mem_wb_pipe_reg_pipe_reg #(
    .W        (PW),
    .CLR_MASK (CLR_MASK)
  ) u_payload (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.flush),
    .stall_i (bus.stall),
    .d_i     (payload_d),
    .q_o     (payload_q)
  );

  assign {bus.validW, bus.rfweW, bus.mtorfselW, bus.aluoutW, bus.dmrdW, bus.rtdW} = payload_q;

  assign load_s = ~bus.flush & ~bus.stall;

  // Retired count advances only when a real instruction is loaded into W; wraps freely.
  always_comb begin
    retired_d = retired_q;
    if (load_s && bus.validM) begin
      retired_d = retired_q + {{(CNT_W - 1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired = retired_q;

  // Write-back mux and forward matches; register 0 is never forwarded.
  always_comb begin
    if (bus.mtorfselW) begin
      bus.wbdataW = bus.dmrdW;
    end else begin
      bus.wbdataW = bus.aluoutW;
    end
    bus.fwdA_W = bus.rfweW && (bus.rtdW == bus.srcA_E) && (bus.srcA_E != {AW{1'b0}});
    bus.fwdB_W = bus.rfweW && (bus.rtdW == bus.srcB_E) && (bus.srcB_E != {AW{1'b0}});
  end

endmodule
